// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the 6502 ALU datapath
//
// Purpose: operation encoding and the BCD nibble correction constant.
// Ports: none (package).
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_AND    = 3'd1,
    ALU_OR     = 3'd2,
    ALU_XOR    = 3'd3,
    ALU_SHR    = 3'd4,
    ALU_SHL    = 3'd5,
    ALU_PASS_B = 3'd6,
    ALU_PASS_A = 3'd7
  } alu_op_t;

  localparam logic [3:0] BCD_ADJ = 4'd6;

endpackage

// File: rtl/alu_bcd_adder.sv
// rtl/alu_bcd_adder.sv - combinational binary/BCD adder for the ALU
//
// Purpose: a + b + carry_in, with optional 6502-style decimal correction.
//   b is the already-effective operand (inverted upstream for SBC/CMP).
// Ports:
//   a, b        operands (WIDTH)
//   carry_in    carry into bit 0
//   decimal_en  apply BCD correction (only meaningful when WIDTH == 8)
//   invert_b    selects subtract-style correction in decimal mode
//   sum         corrected result
//   carry       carry out (binary carry when subtracting)
//   overflow    binary two's-complement overflow, also used in decimal mode
module alu_bcd_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             decimal_en,
  input  logic             invert_b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] bin;

  assign bin      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
  assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (bin[WIDTH-1] != a[WIDTH-1]);

  generate
    if (WIDTH == 8) begin : g_bcd
      logic [4:0] lo_add;
      logic [4:0] hi_add;
      logic [3:0] lo_adj;
      logic [3:0] hi_adj;
      logic       lo_c;
      logic       dec_c;

      always_comb begin
        lo_add = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, carry_in};
        lo_c   = 1'b0;
        hi_add = 5'd0;
        lo_adj = lo_add[3:0];
        hi_adj = 4'd0;
        dec_c  = 1'b0;
        if (!invert_b) begin
          // Add: correct each nibble that exceeds 9 and ripple the decimal carry.
          lo_c = (lo_add > 5'd9);
          if (lo_c) lo_adj = lo_add[3:0] + BCD_ADJ;
          hi_add = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, lo_c};
          dec_c  = (hi_add > 5'd9);
          hi_adj = dec_c ? (hi_add[3:0] + BCD_ADJ) : hi_add[3:0];
        end else begin
          // Subtract: take the binary result and undo the borrow of any nibble
          // that did not produce a carry.
          lo_adj = bin[3:0] - (lo_add[4] ? 4'd0 : BCD_ADJ);
          hi_adj = bin[7:4] - (bin[8] ? 4'd0 : BCD_ADJ);
          dec_c  = bin[8];
        end
      end

      assign sum   = decimal_en ? {hi_adj, lo_adj} : bin[7:0];
      assign carry = decimal_en ? dec_c : bin[8];
    end else begin : g_bin
      assign sum   = bin[WIDTH-1:0];
      assign carry = bin[WIDTH];
    end
  endgenerate

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - registered 8-bit ALU with N/V/Z/C flags for the 6502 datapath
//
// Purpose: selects one of eight operations on A and effective B, registers
//   result and flags every rising edge (1-cycle latency, no enable).
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   input_a       operand A
//   input_b       operand B (inverted when invert_b=1)
//   invert_b      use ~input_b as effective B
//   carry_in      carry into ADD, fill bit for shifts
//   decimal_en    BCD correction on ADD
//   operation     operation select
//   alu_out       registered result
//   carry_out, overflow_out, zero_out, negative_out   registered C/V/Z/N
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             invert_b,
  input  logic             carry_in,
  input  logic             decimal_en,
  input  alu_op_t          operation,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             overflow_out,
  output logic             zero_out,
  output logic             negative_out
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] add_sum;
  logic             add_c;
  logic             add_v;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;

  assign b_eff = invert_b ? ~input_b : input_b;

  alu_bcd_adder #(.WIDTH(WIDTH)) u_adder (
    .a          (input_a),
    .b          (b_eff),
    .carry_in   (carry_in),
    .decimal_en (decimal_en),
    .invert_b   (invert_b),
    .sum        (add_sum),
    .carry      (add_c),
    .overflow   (add_v)
  );

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (operation)
      ALU_ADD: begin
        res   = add_sum;
        res_c = add_c;
        res_v = add_v;
      end
      ALU_AND:    res = input_a & b_eff;
      ALU_OR:     res = input_a | b_eff;
      ALU_XOR:    res = input_a ^ b_eff;
      ALU_SHR: begin
        res   = {carry_in, input_a[WIDTH-1:1]};
        res_c = input_a[0];
      end
      ALU_SHL: begin
        res   = {input_a[WIDTH-2:0], carry_in};
        res_c = input_a[WIDTH-1];
      end
      ALU_PASS_B: res = b_eff;
      ALU_PASS_A: res = input_a;
      default:    res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out      <= '0;
      carry_out    <= 1'b0;
      overflow_out <= 1'b0;
      zero_out     <= 1'b0;
      negative_out <= 1'b0;
    end else begin
      alu_out      <= res;
      carry_out    <= res_c;
      overflow_out <= res_v;
      zero_out     <= (res == '0);
      negative_out <= res[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - self-checking bench for alu_core
module tb_alu_core;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] input_a;
  logic [7:0] input_b;
  logic       invert_b;
  logic       carry_in;
  logic       decimal_en;
  alu_op_t    operation;
  logic [7:0] alu_out;
  logic       carry_out;
  logic       overflow_out;
  logic       zero_out;
  logic       negative_out;

  always #5 clk = ~clk;

  alu_core #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_a      (input_a),
    .input_b      (input_b),
    .invert_b     (invert_b),
    .carry_in     (carry_in),
    .decimal_en   (decimal_en),
    .operation    (operation),
    .alu_out      (alu_out),
    .carry_out    (carry_out),
    .overflow_out (overflow_out),
    .zero_out     (zero_out),
    .negative_out (negative_out)
  );

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       inv;
    logic       cin;
    logic       dec;
    logic [2:0] op;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t mk(input logic [7:0] r, input logic c, input logic v);
    exp_t e;
    e.r = r;
    e.c = c;
    e.v = v;
    e.z = (r == 8'h00);
    e.n = r[7];
    return e;
  endfunction

  function automatic vec_t mkv(input logic [7:0] a, input logic [7:0] b, input logic inv,
                               input logic cin, input logic dec, input logic [2:0] op,
                               input exp_t e);
    vec_t v;
    v.a = a; v.b = b; v.inv = inv; v.cin = cin; v.dec = dec; v.op = op; v.e = e;
    return v;
  endfunction

  // Binary reference model (decimal mode is covered by hand-derived vectors).
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic inv,
                                 input logic cin, input logic [2:0] op);
    logic [7:0] be;
    logic [8:0] s;
    logic [7:0] ov;
    be = inv ? (8'hFF - b) : b;
    case (op)
      3'd0: begin
        s  = 9'(a) + 9'(be) + 9'(cin);
        ov = (a ^ s[7:0]) & (be ^ s[7:0]);
        return mk(s[7:0], s[8], ov[7]);
      end
      3'd1: return mk(a & be, 1'b0, 1'b0);
      3'd2: return mk(a | be, 1'b0, 1'b0);
      3'd3: return mk(a ^ be, 1'b0, 1'b0);
      3'd4: return mk({cin, a[7:1]}, a[0], 1'b0);
      3'd5: return mk({a[6:0], cin}, a[7], 1'b0);
      3'd6: return mk(be, 1'b0, 1'b0);
      default: return mk(a, 1'b0, 1'b0);
    endcase
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.r = alu_out;
    o.c = carry_out;
    o.v = overflow_out;
    o.z = zero_out;
    o.n = negative_out;
    return o;
  endfunction

  // Drives one vector between edges, queues its expectation, and steps past the capturing edge.
  task automatic drive(input vec_t v);
    @(negedge clk);
    input_a    = v.a;
    input_b    = v.b;
    invert_b   = v.inv;
    carry_in   = v.cin;
    decimal_en = v.dec;
    operation  = alu_op_t'(v.op);
    sb.push_back(v.e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string name, input vec_t tbl[$]);
    exp_t e;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      e = sb.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL %s[%0d] got r=%h c=%b v=%b z=%b n=%b expected r=%h c=%b v=%b z=%b n=%b",
                 name, i, alu_out, carry_out, overflow_out, zero_out, negative_out,
                 e.r, e.c, e.v, e.z, e.n);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (observed() !== 12'h000) begin
      failures++;
      $display("FAIL reset_state got %h expected 000", observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    vec_t t[$];
    t.push_back(mkv(8'h50, 8'h50, 0, 0, 0, 3'd0, mk(8'hA0, 0, 1)));
    t.push_back(mkv(8'hFF, 8'h01, 0, 0, 0, 3'd0, mk(8'h00, 1, 0)));
    t.push_back(mkv(8'h7F, 8'h00, 0, 1, 0, 3'd0, mk(8'h80, 0, 1)));
    run_table("add", t);
  endtask

  task automatic test_sub();
    vec_t t[$];
    t.push_back(mkv(8'h05, 8'h05, 1, 1, 0, 3'd0, mk(8'h00, 1, 0)));
    t.push_back(mkv(8'h00, 8'h01, 1, 1, 0, 3'd0, mk(8'hFF, 0, 0)));
    run_table("sub", t);
  endtask

  task automatic test_logic();
    vec_t t[$];
    t.push_back(mkv(8'hF0, 8'h3C, 0, 1, 0, 3'd1, mk(8'h30, 0, 0)));
    t.push_back(mkv(8'hF0, 8'h3C, 0, 1, 0, 3'd2, mk(8'hFC, 0, 0)));
    t.push_back(mkv(8'hF0, 8'h3C, 0, 0, 1, 3'd3, mk(8'hCC, 0, 0)));
    t.push_back(mkv(8'hF0, 8'h3C, 1, 0, 0, 3'd1, mk(8'hC0, 0, 0)));
    t.push_back(mkv(8'h12, 8'h3C, 1, 1, 1, 3'd6, mk(8'hC3, 0, 0)));
    t.push_back(mkv(8'h00, 8'h3C, 0, 1, 0, 3'd7, mk(8'h00, 0, 0)));
    run_table("logic", t);
  endtask

  task automatic test_shift();
    vec_t t[$];
    t.push_back(mkv(8'h81, 8'h00, 0, 1, 0, 3'd4, mk(8'hC0, 1, 0)));
    t.push_back(mkv(8'h81, 8'h00, 0, 0, 0, 3'd5, mk(8'h02, 1, 0)));
    t.push_back(mkv(8'h00, 8'h00, 0, 0, 0, 3'd5, mk(8'h00, 0, 0)));
    t.push_back(mkv(8'h7F, 8'h00, 0, 0, 1, 3'd5, mk(8'hFE, 0, 0)));
    run_table("shift", t);
  endtask

  task automatic test_decimal();
    vec_t t[$];
    t.push_back(mkv(8'h58, 8'h46, 0, 1, 1, 3'd0, mk(8'h05, 1, 1)));
    t.push_back(mkv(8'h12, 8'h34, 0, 0, 1, 3'd0, mk(8'h46, 0, 0)));
    t.push_back(mkv(8'h46, 8'h12, 1, 1, 1, 3'd0, mk(8'h34, 1, 0)));
    t.push_back(mkv(8'h12, 8'h21, 1, 1, 1, 3'd0, mk(8'h91, 0, 0)));
    t.push_back(mkv(8'h09, 8'h00, 0, 0, 1, 3'd0, mk(8'h09, 0, 0)));
    t.push_back(mkv(8'h99, 8'h01, 0, 0, 1, 3'd0, mk(8'h00, 1, 0)));
    run_table("decimal", t);
  endtask

  task automatic test_back_to_back();
    vec_t t[$];
    logic [7:0] a;
    logic [7:0] b;
    logic       inv;
    logic       cin;
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      inv = 1'($urandom);
      cin = 1'($urandom);
      op  = 3'($urandom);
      t.push_back(mkv(a, b, inv, cin, 1'b0, op, model(a, b, inv, cin, op)));
    end
    run_table("back_to_back", t);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge clk);
    input_a    = 8'h50;
    input_b    = 8'h50;
    invert_b   = 1'b0;
    carry_in   = 1'b0;
    decimal_en = 1'b0;
    operation  = ALU_ADD;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== 12'h000) begin
      failures++;
      $display("FAIL reset_async got %h expected 000", observed());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observed() !== 12'h000) begin
      failures++;
      $display("FAIL reset_hold got %h expected 000", observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e = mk(8'hA0, 1'b0, 1'b1);
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("FAIL reset_release got %h expected %h", observed(), e);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    input_a    = 8'h00;
    input_b    = 8'h00;
    invert_b   = 1'b0;
    carry_in   = 1'b0;
    decimal_en = 1'b0;
    operation  = ALU_ADD;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_decimal();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
